// File: rtl/alu_pkg.sv
// Shared definitions for riscv_seq_alu: opcode encodings, FSM state
// encodings and the divide-by-zero quotient constant.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Widest operand the divide-by-zero constant covers; callers truncate.
  localparam int unsigned MAX_WIDTH = 64;

  // Unsigned division by zero returns an all-ones quotient.
  function automatic logic [MAX_WIDTH-1:0] div_by_zero_quot();
    return '1;
  endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit
// per cycle, WIDTH cycles per operation.
// Ports: clk, rst_n (async active-low); start loads a/b and the op flags;
// is_div selects divide, sel_hi selects MULHU / REMU. done_c and result_c
// are combinational and valid in the final iteration cycle, so the parent
// can register the result on the same edge as the last step.
module seq_muldiv_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             sel_hi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] result_c
);

  // hi: product high half / partial remainder; lo: multiplier / dividend
  // shifting out while quotient bits shift in; opnd: multiplicand / divisor.
  logic [WIDTH-1:0] hi, lo, opnd;
  logic [SHW-1:0]   cnt;
  logic             busy, is_div_q, sel_hi_q;

  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
  logic             div_ge;

  // One shift-add / restore step.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], lo[WIDTH-1:1]};
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = !div_diff[WIDTH];
    div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_n  = {lo[WIDTH-2:0], div_ge};
  end

  assign done_c = busy && (cnt == SHW'(WIDTH - 1));

  // A zero divisor leaves the dividend in the remainder naturally; only the
  // quotient is forced.
  always_comb begin
    result_c = '0;
    if (is_div_q) begin
      if (sel_hi_q)          result_c = div_hi_n;
      else if (opnd == '0)   result_c = WIDTH'(div_by_zero_quot());
      else                   result_c = div_lo_n;
    end else begin
      result_c = sel_hi_q ? mul_hi_n : mul_lo_n;
    end
  end

  // Iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
    end else if (start) begin
      hi       <= '0;
      lo       <= a;
      opnd     <= b;
      cnt      <= '0;
      busy     <= 1'b1;
      is_div_q <= is_div;
      sel_hi_q <= sel_hi;
    end else if (busy) begin
      hi  <= is_div_q ? div_hi_n : mul_hi_n;
      lo  <= is_div_q ? div_lo_n : mul_lo_n;
      cnt <= done_c ? '0 : cnt + SHW'(1);
      if (done_c) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_seq_alu.sv
// Registered RV32I-style ALU with valid/ready handshake on both sides and
// one operation in flight. Single-cycle ops load Result on the accept edge;
// with ALU_MULDIV_EN defined, MUL/MULHU/DIVU/REMU run in seq_muldiv_unit and
// complete WIDTH edges after accept. Without ALU_MULDIV_EN those opcodes
// return 0 with latency 1 and no multiply/divide logic exists.
// Ports: clk, rst_n (async active-low); in_valid/in_ready, A, B, ALUControl
// (request side); out_valid/out_ready, Result, Zero (result side).
module riscv_seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  logic             accept;
  logic [WIDTH-1:0] alu_c;
  logic [SHW-1:0]   shamt;

  assign accept = in_valid && in_ready;
  assign shamt  = B[SHW-1:0];
  assign Zero   = (Result == '0);

  // Single-cycle result; everything not listed (incl. mul/div opcodes
  // when they are not built) yields 0.
  always_comb begin
    alu_c = '0;
    case (ALUControl)
      OP_ADD:  alu_c = A + B;
      OP_SUB:  alu_c = A - B;
      OP_AND:  alu_c = A & B;
      OP_OR:   alu_c = A | B;
      OP_XOR:  alu_c = A ^ B;
      OP_SLT:  alu_c = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: alu_c = WIDTH'(A < B);
      OP_SLL:  alu_c = A << shamt;
      OP_SRL:  alu_c = A >> shamt;
      OP_SRA:  alu_c = $unsigned($signed(A) >>> shamt);
      default: alu_c = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  state_t           state;
  logic             is_muldiv, md_done;
  logic [WIDTH-1:0] md_result;

  assign is_muldiv = (ALUControl == OP_MUL)  || (ALUControl == OP_MULHU) ||
                     (ALUControl == OP_DIVU) || (ALUControl == OP_REMU);
  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);

  // Opcode bit 2 separates divide from multiply, bit 0 picks MULHU/REMU.
  seq_muldiv_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && is_muldiv),
    .is_div   (ALUControl[2]),
    .sel_hi   (ALUControl[0]),
    .a        (A),
    .b        (B),
    .done_c   (md_done),
    .result_c (md_result)
  );

  // Control FSM and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      Result    <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_muldiv) begin
              state <= ALUControl[2] ? ST_DIV : ST_MUL;
            end else begin
              Result    <= alu_c;
              out_valid <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_done) begin
            Result    <= md_result;
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  // Output register; every op completes on its accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Result    <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        Result    <= alu_c;
        out_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_seq_alu.sv
// Self-checking bench for riscv_seq_alu (WIDTH=32 main instance plus a
// WIDTH=8 instance). Expected results go to a scoreboard queue when a
// request is accepted and are compared when the DUT presents them.
module tb_riscv_seq_alu;
  import alu_pkg::*;

`ifdef ALU_MULDIV_EN
  localparam bit MD_ON  = 1'b1;
  localparam int MD_LAT = 32;
  localparam int LAT8   = 8;
`else
  localparam bit MD_ON  = 1'b0;
  localparam int MD_LAT = 1;
  localparam int LAT8   = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [31:0] a, b, result;
  logic [3:0]  op;

  logic        iv8, ir8, ov8, or8, z8;
  logic [7:0]  a8, b8, r8;
  logic [3:0]  op8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] exp;
    int          lat;
    int          acc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  bit   fresh = 1'b1;

  riscv_seq_alu #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .ALUControl(op), .out_valid(out_valid),
    .out_ready(out_ready), .Result(result), .Zero(zero)
  );

  riscv_seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .ALUControl(op8), .out_valid(ov8),
    .out_ready(or8), .Result(r8), .Zero(z8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] md(input logic [31:0] v);
    return MD_ON ? v : 32'h0;
  endfunction

  function automatic int lat_of(input logic [3:0] o);
    return (MD_ON && o >= OP_MUL && o <= OP_REMU) ? MD_LAT : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one request from a negedge; returns at the negedge after accept.
  task automatic issue(input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] e,
                       input bit push);
    int waited = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout op=%h in_ready=%b", o, in_ready);
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{o, e, lat_of(o), cyc});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #2;
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: a result is new unless it was held under backpressure.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!out_valid) begin
        fresh = 1'b1;
      end else begin
        if (fresh) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_result actual=%h required=none", result);
          end else begin
            sb_t e;
            e = sb.pop_front();
            check($sformatf("result_op%h", e.op), result, e.exp);
            check($sformatf("zero_op%h", e.op), 32'(zero), 32'(e.exp == 32'h0));
            check($sformatf("latency_op%h", e.op), 32'(cyc - e.acc), 32'(e.lat));
          end
        end
        fresh = out_ready;
      end
    end
  end

  initial begin
    int hi_cnt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; op8 = '0;

    vecs.push_back('{OP_ADD,   32'd3,        32'd4,        32'd7});
    vecs.push_back('{OP_ADD,   32'hFFFFFFFF, 32'd1,        32'h0});
    vecs.push_back('{OP_SUB,   32'd5,        32'd5,        32'h0});
    vecs.push_back('{OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd1});
    vecs.push_back('{OP_SRA,   32'h80000000, 32'd4,        32'hF8000000});
    vecs.push_back('{OP_SUB,   32'd0,        32'd1,        32'hFFFFFFFF});
    vecs.push_back('{OP_AND,   32'h0000F0F0, 32'h0000FF00, 32'h0000F000});
    vecs.push_back('{OP_OR,    32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0});
    vecs.push_back('{OP_XOR,   32'h0000AAAA, 32'h0000FFFF, 32'h00005555});
    vecs.push_back('{OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0});
    vecs.push_back('{OP_SLT,   32'd1,        32'hFFFFFFFF, 32'd0});
    vecs.push_back('{OP_SLL,   32'd1,        32'd31,       32'h80000000});
    vecs.push_back('{OP_SLL,   32'd1,        32'h21,       32'd2});
    vecs.push_back('{OP_SRL,   32'h80000000, 32'd4,        32'h08000000});
    vecs.push_back('{4'b1110,  32'd9,        32'd9,        32'h0});
    vecs.push_back('{4'b1111,  32'd9,        32'd9,        32'h0});
    vecs.push_back('{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, md(32'hFFFFFFFE)});
    vecs.push_back('{OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, md(32'h00000001)});
    vecs.push_back('{OP_MUL,   32'd7,        32'd6,        md(32'd42)});
    vecs.push_back('{OP_MULHU, 32'h00010000, 32'h00010000, md(32'd1)});
    vecs.push_back('{OP_DIVU,  32'd100,      32'd7,        md(32'd14)});
    vecs.push_back('{OP_REMU,  32'd100,      32'd7,        md(32'd2)});
    vecs.push_back('{OP_DIVU,  32'd9,        32'd0,        md(32'hFFFFFFFF)});
    vecs.push_back('{OP_REMU,  32'd9,        32'd0,        md(32'd9)});
    vecs.push_back('{OP_ADD,   32'd2,        32'd2,        32'd4});

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst8_zero", 32'(z8), 32'd1);
    check("rst8_in_ready", 32'(ir8), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven stream with out_ready held high.
    foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
    drain();

    // Backpressure: result held, no new accept until consumer is ready.
    @(negedge clk);
    out_ready = 1'b0;
    issue(OP_ADD, 32'd3, 32'd4, 32'd7, 1'b1);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", result, 32'd7);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk); #1;
    end
    @(negedge clk);
    op = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    #1;
    check("busy_in_ready", 32'(in_ready), 32'd0);
    check("busy_result", result, 32'd7);
    @(negedge clk);
    out_ready = 1'b1;
    issue(OP_ADD, 32'd1, 32'd1, 32'd2, 1'b1);
    drain();

`ifdef ALU_MULDIV_EN
    // Reset in the middle of a multiply: nothing may emerge afterwards.
    @(negedge clk);
    issue(OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0);
    op = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("mul_busy_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", 32'(zero), 32'd1);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    hi_cnt = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (out_valid) hi_cnt++;
    end
    check("midrst_no_result", 32'(hi_cnt), 32'd0);
    @(negedge clk);
    issue(OP_SUB, 32'd10, 32'd3, 32'd7, 1'b1);
    drain();
`endif

    // WIDTH=8 instance: opcode 1010 and shift amount truncation.
    @(negedge clk);
    op8 = OP_MUL; a8 = 8'd3; b8 = 8'd5; iv8 = 1'b1;
    #1;
    check("w8_in_ready", 32'(ir8), 32'd1);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (LAT8 - 1) @(negedge clk);
    #1;
    check("w8_op1010_valid", 32'(ov8), 32'd1);
    check("w8_op1010_result", 32'(r8), MD_ON ? 32'd15 : 32'd0);
    @(negedge clk);
    op8 = OP_SLL; a8 = 8'h81; b8 = 8'd9; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    #1;
    check("w8_sll_valid", 32'(ov8), 32'd1);
    check("w8_sll_result", 32'(r8), 32'h02);
    check("w8_sll_zero", 32'(z8), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
